// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the 16-bit TSC-style ISA: sequences IF/ID/EX/MEM/WB,
// drives datapath selectors and strobes, counts retired instructions, detects halt/illegal.
module multicycle_control_unit #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] inst,
    input  logic                 mem_ready,
    input  logic                 bcond,
    output logic                 pc_we,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 i_or_d,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           alu_control,
    output logic [1:0]           pc_src,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           wb_src,
    output logic                 output_en,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] num_inst,
    output logic                 halted,
    output logic                 illegal
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_RTY = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_SHL = 3'd6;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_WIDTH-1:0]   r_num_inst;
    logic                   r_illegal;
    logic                   w_illegal_set;

    logic [3:0]             w_opcode;
    logic [5:0]             w_func;
    logic                   w_is_rtype;
    logic                   w_is_alu_func;
    logic                   w_is_branch;
    logic                   w_illegal;
    logic                   w_unused;

    assign w_opcode      = inst[WORD_SIZE-1 -: 4];
    assign w_func        = inst[5:0];
    assign w_unused      = ^inst[WORD_SIZE-5:6];
    assign w_is_rtype    = (w_opcode == OP_RTY);
    assign w_is_alu_func = (w_func < 6'd8);
    assign w_is_branch   = (w_opcode == OP_BNE) || (w_opcode == OP_BEQ) ||
                           (w_opcode == OP_BGZ) || (w_opcode == OP_BLZ);
    // Opcodes 11..14 are unassigned; R-type accepts only ALU funcs and the special ops
    assign w_illegal     = ((w_opcode > OP_JAL) && !w_is_rtype) ||
                           (w_is_rtype && !w_is_alu_func &&
                            (w_func != FN_JPR) && (w_func != FN_JRL) &&
                            (w_func != FN_WWD) && (w_func != FN_HLT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IF;
            r_num_inst <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (retire) begin
                r_num_inst <= r_num_inst + CNT_WIDTH'(1);
            end
            if (w_illegal_set) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        pc_we         = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_control   = ALU_ADD;
        pc_src        = 2'd0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        wb_src        = 2'd0;
        output_en     = 1'b0;
        retire        = 1'b0;
        w_illegal_set = 1'b0;
        w_state_next  = r_state;

        // Outputs are forced idle while reset is high so an aborted access writes nothing
        if (!reset) begin
            unique case (r_state)
                S_IF: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'd1;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        pc_we        = 1'b1;
                        w_state_next = S_ID;
                    end
                end
                S_ID: begin
                    alu_src_b = 2'd2;
                    if (w_illegal) begin
                        w_illegal_set = 1'b1;
                        w_state_next  = S_HALT;
                    end else if (w_opcode == OP_JMP || w_opcode == OP_JAL) begin
                        pc_we        = 1'b1;
                        pc_src       = 2'd2;
                        retire       = 1'b1;
                        w_state_next = S_IF;
                        if (w_opcode == OP_JAL) begin
                            reg_write = 1'b1;
                            reg_dst   = 2'd2;
                            wb_src    = 2'd2;
                        end
                    end else if (w_is_rtype && (w_func == FN_JPR || w_func == FN_JRL)) begin
                        pc_we        = 1'b1;
                        pc_src       = 2'd3;
                        retire       = 1'b1;
                        w_state_next = S_IF;
                        if (w_func == FN_JRL) begin
                            reg_write = 1'b1;
                            reg_dst   = 2'd2;
                            wb_src    = 2'd2;
                        end
                    end else if (w_is_rtype && w_func == FN_WWD) begin
                        output_en    = 1'b1;
                        retire       = 1'b1;
                        w_state_next = S_IF;
                    end else if (w_is_rtype && w_func == FN_HLT) begin
                        retire       = 1'b1;
                        w_state_next = S_HALT;
                    end else begin
                        w_state_next = S_EX;
                    end
                end
                S_EX: begin
                    alu_src_a = 1'b1;
                    if (w_is_rtype) begin
                        alu_src_b    = 2'd0;
                        alu_control  = w_func[2:0];
                        w_state_next = S_WB;
                    end else if (w_is_branch) begin
                        alu_src_b    = 2'd0;
                        alu_control  = ALU_SUB;
                        pc_we        = bcond;
                        pc_src       = 2'd1;
                        retire       = 1'b1;
                        w_state_next = S_IF;
                    end else if (w_opcode == OP_ORI) begin
                        alu_src_b    = 2'd3;
                        alu_control  = ALU_ORR;
                        w_state_next = S_WB;
                    end else if (w_opcode == OP_LHI) begin
                        alu_src_b    = 2'd3;
                        alu_control  = ALU_SHL;
                        w_state_next = S_WB;
                    end else if (w_opcode == OP_ADI) begin
                        alu_src_b    = 2'd2;
                        w_state_next = S_WB;
                    end else if (w_opcode == OP_LWD || w_opcode == OP_SWD) begin
                        alu_src_b    = 2'd2;
                        w_state_next = S_MEM;
                    end else begin
                        w_state_next = S_IF;
                    end
                end
                S_MEM: begin
                    i_or_d = 1'b1;
                    if (w_opcode == OP_SWD) begin
                        mem_write = 1'b1;
                        if (mem_ready) begin
                            retire       = 1'b1;
                            w_state_next = S_IF;
                        end
                    end else begin
                        mem_read = 1'b1;
                        if (mem_ready) begin
                            w_state_next = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_write    = 1'b1;
                    retire       = 1'b1;
                    reg_dst      = w_is_rtype ? 2'd1 : 2'd0;
                    wb_src       = (w_opcode == OP_LWD) ? 2'd1 : 2'd0;
                    w_state_next = S_IF;
                end
                S_HALT: begin
                    w_state_next = S_HALT;
                end
                default: begin
                    w_state_next = S_IF;
                end
            endcase
        end
    end

    assign num_inst = r_num_inst;
    assign illegal  = r_illegal;
    assign halted   = (r_state == S_HALT);

endmodule
